// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback stage: memory-mode codes, FSM states and the
// latched command bundle.
package writeback_unit_pkg;

   // Memory access modes carried with each command; 2'b11 is reserved and
   // behaves as a plain writeback.
   typedef enum logic [1:0] {
      MEM_NOP   = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b10,
      MEM_RSVD  = 2'b11
   } mem_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ACCESS   = 2'b01,
      ST_COMPLETE = 2'b10
   } wb_state_e;

   // Everything captured from upstream when a command is accepted.
   typedef struct packed {
      logic [15:0] alu_out;
      logic [15:0] store_data;
      logic [2:0]  rd_sel;
      logic        write_rd;
      logic        write_pc;
      mem_mode_e   mode;
   } cmd_t;

   function automatic logic is_mem_op(input mem_mode_e m);
      return (m == MEM_READ) || (m == MEM_WRITE);
   endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Data-memory request/acknowledge bus between the writeback unit (master)
// and data memory (slave).
interface writeback_unit_if;
   logic        O_mem_req;
   logic        O_mem_we;
   logic [15:0] O_mem_addr;
   logic [15:0] O_mem_wdata;
   logic        I_mem_ack;
   logic [15:0] I_mem_rdata;

   modport master (
      output O_mem_req, O_mem_we, O_mem_addr, O_mem_wdata,
      input  I_mem_ack, I_mem_rdata
   );

   modport slave (
      input  O_mem_req, O_mem_we, O_mem_addr, O_mem_wdata,
      output I_mem_ack, I_mem_rdata
   );
endinterface

// File: rtl/writeback_unit.sv
// Memory/writeback stage: latches an ALU result bundle, performs an optional
// data-memory access with timeout, then pulses register-file / PC strobes.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             I_clk,
   input  logic             I_reset,
   input  logic             I_enable,
   input  logic [15:0]      I_alu_out,
   input  logic [15:0]      I_store_data,
   input  logic [2:0]       I_rD_sel,
   input  logic             I_write_rD,
   input  logic             I_write_pc,
   input  logic [1:0]       I_memory_mode,
   writeback_unit_if.master mem,
   output logic             O_reg_we,
   output logic [2:0]       O_reg_sel,
   output logic [15:0]      O_reg_data,
   output logic             O_pc_we,
   output logic [15:0]      O_pc,
   output logic             O_busy,
   output logic             O_done,
   output logic             O_error
);

   // Count value at which an unacknowledged access gives up.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   wb_state_e   state_q, state_d;
   cmd_t        cmd_q, cmd_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        accept;
   logic        ack_hit;
   logic        timeout_hit;

   // Qualify handshake events against the current state.
   always_comb begin
      accept      = (state_q == ST_IDLE) && I_enable;
      ack_hit     = (state_q == ST_ACCESS) && mem.I_mem_ack;
      timeout_hit = (TIMEOUT != 0) && (state_q == ST_ACCESS) &&
                    !mem.I_mem_ack && (cnt_q == TMO_LAST);
   end

   // State register.
   always_ff @(posedge I_clk) begin
      if (I_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; an ack in the final wait cycle wins over the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_mem_op(mem_mode_e'(I_memory_mode))) state_d = ST_ACCESS;
               else                                      state_d = ST_COMPLETE;
            end
         end
         ST_ACCESS: begin
            if (ack_hit)          state_d = ST_COMPLETE;
            else if (timeout_hit) state_d = ST_IDLE;
         end
         ST_COMPLETE: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Next values for the command latch, wait counter, read capture and error pulse.
   always_comb begin
      cmd_d   = cmd_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = timeout_hit;
      if (accept) begin
         cmd_d.alu_out    = I_alu_out;
         cmd_d.store_data = I_store_data;
         cmd_d.rd_sel     = I_rD_sel;
         cmd_d.write_rd   = I_write_rD;
         cmd_d.write_pc   = I_write_pc;
         cmd_d.mode       = mem_mode_e'(I_memory_mode);
         cnt_d            = '0;
      end else if ((state_q == ST_ACCESS) && !mem.I_mem_ack) begin
         cnt_d = cnt_q + 16'd1;
      end
      if (ack_hit && (cmd_q.mode == MEM_READ)) rdata_d = mem.I_mem_rdata;
   end

   // Datapath registers; all clear on reset so every output reads zero.
   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         cmd_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Output decode from state and latched command.
   always_comb begin
      mem.O_mem_req   = (state_q == ST_ACCESS);
      mem.O_mem_we    = (cmd_q.mode == MEM_WRITE);
      mem.O_mem_addr  = cmd_q.alu_out;
      mem.O_mem_wdata = cmd_q.store_data;
      O_done          = (state_q == ST_COMPLETE);
      O_reg_we        = (state_q == ST_COMPLETE) && cmd_q.write_rd &&
                        (cmd_q.mode != MEM_WRITE);
      O_reg_sel       = cmd_q.rd_sel;
      O_reg_data      = (cmd_q.mode == MEM_READ) ? rdata_q : cmd_q.alu_out;
      O_pc_we         = (state_q == ST_COMPLETE) && cmd_q.write_pc &&
                        !is_mem_op(cmd_q.mode);
      O_pc            = cmd_q.alu_out;
      O_busy          = (state_q != ST_IDLE);
      O_error         = err_q;
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: NOP/JMP writeback, read with waits,
// write with immediate ack, timeout, and reset during an access.
module tb_writeback_unit;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] alu_out;
   logic [15:0] store_data;
   logic [2:0]  rd_sel;
   logic        write_rd;
   logic        write_pc;
   logic [1:0]  mode;
   logic        reg_we;
   logic [2:0]  reg_sel;
   logic [15:0] reg_data;
   logic        pc_we;
   logic [15:0] pc;
   logic        busy;
   logic        done;
   logic        error;

   int n_vec = 0;
   int n_bad = 0;

   writeback_unit_if mem_if ();

   writeback_unit #(.TIMEOUT(4)) dut (
      .I_clk         (clk),
      .I_reset       (rst),
      .I_enable      (en),
      .I_alu_out     (alu_out),
      .I_store_data  (store_data),
      .I_rD_sel      (rd_sel),
      .I_write_rD    (write_rd),
      .I_write_pc    (write_pc),
      .I_memory_mode (mode),
      .mem           (mem_if),
      .O_reg_we      (reg_we),
      .O_reg_sel     (reg_sel),
      .O_reg_data    (reg_data),
      .O_pc_we       (pc_we),
      .O_pc          (pc),
      .O_busy        (busy),
      .O_done        (done),
      .O_error       (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, ".req"},   32'(mem_if.O_mem_req),   32'h0);
      check_eq({tag, ".we"},    32'(mem_if.O_mem_we),    32'h0);
      check_eq({tag, ".addr"},  32'(mem_if.O_mem_addr),  32'h0);
      check_eq({tag, ".wdata"}, 32'(mem_if.O_mem_wdata), 32'h0);
      check_eq({tag, ".reg_we"},  32'(reg_we),   32'h0);
      check_eq({tag, ".reg_sel"}, 32'(reg_sel),  32'h0);
      check_eq({tag, ".reg_data"},32'(reg_data), 32'h0);
      check_eq({tag, ".pc_we"},   32'(pc_we),    32'h0);
      check_eq({tag, ".pc"},      32'(pc),       32'h0);
      check_eq({tag, ".busy"},    32'(busy),     32'h0);
      check_eq({tag, ".done"},    32'(done),     32'h0);
      check_eq({tag, ".error"},   32'(error),    32'h0);
   endtask

   // Present a command for one edge; returns at the negedge of cycle N+1.
   task automatic issue(input logic [1:0] m, input logic [15:0] a, input logic [15:0] sd,
                        input logic [2:0] sel, input logic wrd, input logic wpc);
      en         = 1'b1;
      mode       = m;
      alu_out    = a;
      store_data = sd;
      rd_sel     = sel;
      write_rd   = wrd;
      write_pc   = wpc;
      @(negedge clk);
      en = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0;
      alu_out = '0;
      store_data = '0;
      rd_sel = '0;
      write_rd = 1'b0;
      write_pc = 1'b0;
      mode = 2'b00;
      mem_if.I_mem_ack = 1'b0;
      mem_if.I_mem_rdata = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // ALU writeback
      issue(2'b00, 16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0);
      check_eq("alu.reg_we",   32'(reg_we),   32'h1);
      check_eq("alu.reg_sel",  32'(reg_sel),  32'h3);
      check_eq("alu.reg_data", 32'(reg_data), 32'h1234);
      check_eq("alu.done",     32'(done),     32'h1);
      check_eq("alu.busy",     32'(busy),     32'h1);
      check_eq("alu.pc_we",    32'(pc_we),    32'h0);
      check_eq("alu.req",      32'(mem_if.O_mem_req), 32'h0);
      @(negedge clk);
      check_eq("alu.idle_busy", 32'(busy),   32'h0);
      check_eq("alu.idle_done", 32'(done),   32'h0);
      check_eq("alu.idle_we",   32'(reg_we), 32'h0);
      check_eq("alu.idle_req",  32'(mem_if.O_mem_req), 32'h0);

      // Jump: PC write only
      issue(2'b00, 16'h0040, 16'h0000, 3'd0, 1'b0, 1'b1);
      check_eq("jmp.pc_we",  32'(pc_we),  32'h1);
      check_eq("jmp.pc",     32'(pc),     32'h0040);
      check_eq("jmp.reg_we", 32'(reg_we), 32'h0);
      check_eq("jmp.done",   32'(done),   32'h1);
      @(negedge clk);
      check_eq("jmp.pc_we_off", 32'(pc_we), 32'h0);

      // Read with three wait cycles; enable pulses mid-access must be ignored
      issue(2'b01, 16'h0100, 16'h0000, 3'd5, 1'b1, 1'b1);
      for (int c = 0; c < 4; c++) begin
         check_eq($sformatf("rd.req%0d", c),  32'(mem_if.O_mem_req),  32'h1);
         check_eq($sformatf("rd.addr%0d", c), 32'(mem_if.O_mem_addr), 32'h0100);
         check_eq($sformatf("rd.we%0d", c),   32'(mem_if.O_mem_we),   32'h0);
         check_eq($sformatf("rd.done%0d", c), 32'(done),              32'h0);
         en = (c == 1 || c == 2);
         mode = 2'b00;
         alu_out = 16'hDEAD;
         if (c == 3) begin
            mem_if.I_mem_ack = 1'b1;
            mem_if.I_mem_rdata = 16'hBEEF;
         end
         @(negedge clk);
      end
      mem_if.I_mem_ack = 1'b0;
      mem_if.I_mem_rdata = 16'h0000;
      check_eq("rd.req_off",  32'(mem_if.O_mem_req), 32'h0);
      check_eq("rd.reg_we",   32'(reg_we),   32'h1);
      check_eq("rd.reg_data", 32'(reg_data), 32'hBEEF);
      check_eq("rd.reg_sel",  32'(reg_sel),  32'h5);
      check_eq("rd.pc_we",    32'(pc_we),    32'h0);
      check_eq("rd.done",     32'(done),     32'h1);
      @(negedge clk);
      check_eq("rd.no_queue_busy", 32'(busy), 32'h0);
      check_eq("rd.no_queue_done", 32'(done), 32'h0);

      // Write, acked on the first request cycle
      issue(2'b10, 16'h0200, 16'hCAFE, 3'd2, 1'b1, 1'b0);
      check_eq("wr.req",   32'(mem_if.O_mem_req),   32'h1);
      check_eq("wr.we",    32'(mem_if.O_mem_we),    32'h1);
      check_eq("wr.addr",  32'(mem_if.O_mem_addr),  32'h0200);
      check_eq("wr.wdata", 32'(mem_if.O_mem_wdata), 32'hCAFE);
      mem_if.I_mem_ack = 1'b1;
      mem_if.I_mem_rdata = 16'h1111;
      @(negedge clk);
      mem_if.I_mem_ack = 1'b0;
      check_eq("wr.req_off", 32'(mem_if.O_mem_req), 32'h0);
      check_eq("wr.reg_we",  32'(reg_we), 32'h0);
      check_eq("wr.done",    32'(done),   32'h1);
      @(negedge clk);
      check_eq("wr.idle", 32'(busy), 32'h0);

      // Stray ack while idle
      mem_if.I_mem_ack = 1'b1;
      @(negedge clk);
      mem_if.I_mem_ack = 1'b0;
      check_eq("stray.req",  32'(mem_if.O_mem_req), 32'h0);
      check_eq("stray.busy", 32'(busy), 32'h0);
      check_eq("stray.done", 32'(done), 32'h0);

      // Timeout: request held exactly four cycles, then error pulse
      issue(2'b01, 16'h0300, 16'h0000, 3'd1, 1'b1, 1'b1);
      for (int c = 0; c < 4; c++) begin
         check_eq($sformatf("tmo.req%0d", c), 32'(mem_if.O_mem_req), 32'h1);
         check_eq($sformatf("tmo.err%0d", c), 32'(error), 32'h0);
         @(negedge clk);
      end
      check_eq("tmo.req_off", 32'(mem_if.O_mem_req), 32'h0);
      check_eq("tmo.error",   32'(error),  32'h1);
      check_eq("tmo.reg_we",  32'(reg_we), 32'h0);
      check_eq("tmo.pc_we",   32'(pc_we),  32'h0);
      check_eq("tmo.done",    32'(done),   32'h0);
      check_eq("tmo.busy",    32'(busy),   32'h0);
      issue(2'b00, 16'h5555, 16'h0000, 3'd4, 1'b1, 1'b0);
      check_eq("tmo.next_done", 32'(done),     32'h1);
      check_eq("tmo.next_data", 32'(reg_data), 32'h5555);
      check_eq("tmo.err_off",   32'(error),    32'h0);
      @(negedge clk);

      // Reset while the access is outstanding
      issue(2'b01, 16'h0400, 16'h7777, 3'd6, 1'b1, 1'b0);
      check_eq("rst.req_on", 32'(mem_if.O_mem_req), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("rst");
      mem_if.I_mem_ack = 1'b1;
      mem_if.I_mem_rdata = 16'hABCD;
      @(negedge clk);
      mem_if.I_mem_ack = 1'b0;
      check_eq("rst.late_we",   32'(reg_we), 32'h0);
      check_eq("rst.late_done", 32'(done),   32'h0);
      check_eq("rst.late_busy", 32'(busy),   32'h0);
      check_eq("rst.late_req",  32'(mem_if.O_mem_req), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
